// File: rtl/jk_mod_counter.sv
// Mod-MODULO up/down counter whose state bits are edge-triggered JK cells.
// Decode computes the next count; each cell receives J/K derived from it.
module jk_mod_counter #(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned MODULO = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qm,
  output logic             tc,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULO - 1);

  logic [WIDTH-1:0] next_q;
  logic [WIDTH-1:0] j;
  logic [WIDTH-1:0] k;
  logic             at_term;

  assign at_term = up_dn ? (q == MAX_VAL) : (q == '0);
  assign tc      = en & ~load & at_term;
  assign qm      = ~q;

  always_comb begin
    next_q = q;
    if (load) begin
      next_q = (d > MAX_VAL) ? MAX_VAL : d;
    end else if (en) begin
      if (up_dn) next_q = (q == MAX_VAL) ? '0 : q + 1'b1;
      else       next_q = (q == '0) ? MAX_VAL : q - 1'b1;
    end
  end

  // J sets a bit that must rise, K clears a bit that must fall; never both.
  assign j = ~q & next_q;
  assign k = q & ~next_q;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    logic q_bit;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        q_bit <= 1'b0;
      end else begin
        case ({j[i], k[i]})
          2'b10:   q_bit <= 1'b1;
          2'b01:   q_bit <= 1'b0;
          2'b11:   q_bit <= ~q_bit;
          default: q_bit <= q_bit;
        endcase
      end
    end

    assign q[i] = q_bit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wrap <= 1'b0;
    else        wrap <= tc;
  end

endmodule

// File: tb/tb_jk_mod_counter.sv
// Directed self-checking bench for jk_mod_counter (WIDTH=4, MODULO=10).
module tb_jk_mod_counter;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       up_dn;
  logic       load;
  logic [3:0] d;
  logic [3:0] q;
  logic [3:0] qm;
  logic       tc;
  logic       wrap;

  int checks = 0;
  int errors = 0;

  jk_mod_counter #(.WIDTH(4), .MODULO(10)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .up_dn (up_dn),
    .load  (load),
    .d     (d),
    .q     (q),
    .qm    (qm),
    .tc    (tc),
    .wrap  (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    checks++;
    if (qm !== ~q) begin
      errors++;
      $display("FAIL inv_qm q=%h qm=%h want %h", q, qm, ~q);
    end
    checks++;
    if (!(q < 4'd10)) begin
      errors++;
      $display("FAIL inv_range q=%0d want <10", q);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1; up_dn = 1'b0; load = 1'b0; d = '0;
    #3;
    checks++;
    if (q !== 4'd0 || qm !== 4'hF || wrap !== 1'b0) begin
      errors++;
      $display("FAIL reset_state q=%h qm=%h wrap=%b want 0 F 0", q, qm, wrap);
    end
    checks++;
    if (tc !== 1'b1) begin
      errors++;
      $display("FAIL reset_tc tc=%b want 1", tc);
    end
    @(negedge clk);
    rst_n = 1'b1; en = 1'b0; load = 1'b1; d = 4'd7;
    tick();
    checks++;
    if (q !== 4'd7) begin
      errors++;
      $display("FAIL reset_preload q=%0d want 7", q);
    end
    load = 1'b0; en = 1'b1; up_dn = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (q !== 4'd0 || qm !== 4'hF || wrap !== 1'b0) begin
      errors++;
      $display("FAIL reset_async q=%h qm=%h wrap=%b want 0 F 0", q, qm, wrap);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checks++;
    if (q !== 4'd1) begin
      errors++;
      $display("FAIL reset_release q=%0d want 1", q);
    end
  endtask

  task automatic test_up_wrap();
    load = 1'b1; en = 1'b0; d = 4'd0;
    tick();
    load = 1'b0; en = 1'b1; up_dn = 1'b1;
    #1;
    checks++;
    if (q !== 4'd0 || tc !== 1'b0) begin
      errors++;
      $display("FAIL up_start q=%0d tc=%b want 0 0", q, tc);
    end
    for (int unsigned n = 1; n <= 12; n++) begin
      tick();
      checks++;
      if (q !== 4'(n % 10)) begin
        errors++;
        $display("FAIL up_q step %0d q=%0d want %0d", n, q, n % 10);
      end
      checks++;
      if (tc !== (n == 9)) begin
        errors++;
        $display("FAIL up_tc step %0d tc=%b want %b", n, tc, n == 9);
      end
      checks++;
      if (wrap !== (n == 10)) begin
        errors++;
        $display("FAIL up_wrap step %0d wrap=%b want %b", n, wrap, n == 10);
      end
    end
  endtask

  task automatic test_down_wrap();
    logic [3:0] exp_q  [3] = '{4'd0, 4'd9, 4'd8};
    logic       exp_tc [3] = '{1'b1, 1'b0, 1'b0};
    logic       exp_wr [3] = '{1'b0, 1'b1, 1'b0};
    load = 1'b1; en = 1'b1; up_dn = 1'b0; d = 4'd1;
    tick();
    checks++;
    if (q !== 4'd1 || wrap !== 1'b0) begin
      errors++;
      $display("FAIL down_load q=%0d wrap=%b want 1 0", q, wrap);
    end
    load = 1'b0;
    for (int unsigned n = 0; n < 3; n++) begin
      tick();
      checks++;
      if (q !== exp_q[n] || tc !== exp_tc[n] || wrap !== exp_wr[n]) begin
        errors++;
        $display("FAIL down_step %0d q=%0d tc=%b wrap=%b want %0d %b %b",
                 n, q, tc, wrap, exp_q[n], exp_tc[n], exp_wr[n]);
      end
    end
  endtask

  task automatic test_load();
    logic [3:0] ld_d  [4] = '{4'd5, 4'd13, 4'd2, 4'd10};
    logic [3:0] ld_q  [4] = '{4'd5, 4'd9,  4'd2, 4'd9};
    en = 1'b1; up_dn = 1'b1; load = 1'b1;
    for (int unsigned n = 0; n < 4; n++) begin
      d = ld_d[n];
      #1;
      checks++;
      if (tc !== 1'b0) begin
        errors++;
        $display("FAIL load_tc %0d tc=%b want 0", n, tc);
      end
      tick();
      checks++;
      if (q !== ld_q[n] || wrap !== 1'b0) begin
        errors++;
        $display("FAIL load_q d=%0d q=%0d wrap=%b want %0d 0", ld_d[n], q, wrap, ld_q[n]);
      end
    end
    load = 1'b0;
    #1;
    checks++;
    if (tc !== 1'b1) begin
      errors++;
      $display("FAIL load_term_tc tc=%b want 1", tc);
    end
  endtask

  task automatic test_hold_dir();
    logic [3:0] dir_q [4] = '{4'd4, 4'd3, 4'd4, 4'd3};
    load = 1'b1; en = 1'b0; d = 4'd3;
    tick();
    load = 1'b0;
    for (int unsigned n = 0; n < 4; n++) begin
      tick();
      checks++;
      if (q !== 4'd3 || tc !== 1'b0 || wrap !== 1'b0) begin
        errors++;
        $display("FAIL hold %0d q=%0d tc=%b wrap=%b want 3 0 0", n, q, tc, wrap);
      end
    end
    en = 1'b1;
    for (int unsigned n = 0; n < 4; n++) begin
      up_dn = (n % 2 == 0);
      tick();
      checks++;
      if (q !== dir_q[n]) begin
        errors++;
        $display("FAIL dir_change %0d q=%0d want %0d", n, q, dir_q[n]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_up_wrap();
    test_down_wrap();
    test_load();
    test_hold_dir();
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
